// File: rtl/aluv_pipe_if.sv
// Handshake and data bundle for aluv_pipe. The sat port exists only when
// ALUV_SAT_EN is defined.
interface aluv_pipe_if #(
    parameter int VLEN = 128
);
    logic              in_valid;
    logic              in_ready;
    logic [VLEN-1:0]   operandA;
    logic [VLEN-1:0]   operandB;
    logic [2:0]        command;
    logic [2:0]        dtype;
`ifdef ALUV_SAT_EN
    logic              sat;
`endif
    logic              out_valid;
    logic              out_ready;
    logic [VLEN-1:0]   result;
    logic              iszero;
    logic [VLEN/8-1:0] ovf;
    logic              err;

`ifdef ALUV_SAT_EN
    modport master (
        output in_valid, operandA, operandB, command, dtype, sat, out_ready,
        input  in_ready, out_valid, result, iszero, ovf, err
    );
    modport slave (
        input  in_valid, operandA, operandB, command, dtype, sat, out_ready,
        output in_ready, out_valid, result, iszero, ovf, err
    );
`else
    modport master (
        output in_valid, operandA, operandB, command, dtype, out_ready,
        input  in_ready, out_valid, result, iszero, ovf, err
    );
    modport slave (
        input  in_valid, operandA, operandB, command, dtype, out_ready,
        output in_ready, out_valid, result, iszero, ovf, err
    );
`endif
endinterface

// File: rtl/aluv_pipe.sv
// Lane-wise vector ALU behind an LAT-stage valid/ready pipeline with bubble
// collapse. Define ALUV_SAT_EN to add signed saturation for ADD/SUB.
module aluv_pipe #(
    parameter int VLEN = 128,
    parameter int LAT  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    aluv_pipe_if.slave  bus
);
    localparam int NB = VLEN / 8;

    logic [3:0][VLEN-1:0] arith_s;
    logic [3:0][VLEN-1:0] slt_s;
    logic [3:0][NB-1:0]   lane_ovf_s;
    logic                 sub_s;
    logic [VLEN-1:0]      res_s;
    logic [NB-1:0]        ovf_s;
    logic                 err_s;
    logic                 zero_s;
    logic [LAT-1:0]       adv_s;

    logic [LAT-1:0]       vld_r;
    logic [VLEN-1:0]      res_r [LAT];
    logic [NB-1:0]        ovf_r [LAT];
    logic [LAT-1:0]       err_r;
    logic [LAT-1:0]       zero_r;

    assign sub_s = (bus.command == 3'd1);

    // One arithmetic datapath per lane width; g selects BYTE/HALF/WORD/DWORD.
    for (genvar g = 0; g < 4; g++) begin : g_w
        localparam int W = 8 << g;
        for (genvar l = 0; l < VLEN / W; l++) begin : g_lane
            logic [W-1:0] a_s;
            logic [W-1:0] b_s;
            logic [W-1:0] sum_s;
            logic [W-1:0] dif_s;
            logic [W-1:0] raw_s;
            logic         ov_s;

            assign a_s   = bus.operandA[l*W +: W];
            assign b_s   = bus.operandB[l*W +: W];
            assign sum_s = a_s + b_s;
            assign dif_s = a_s - b_s;
            assign raw_s = sub_s ? dif_s : sum_s;
            // Signed overflow: the true result always carries A's sign when it overflows.
            assign ov_s  = sub_s ? ((a_s[W-1] != b_s[W-1]) && (dif_s[W-1] != a_s[W-1]))
                                 : ((a_s[W-1] == b_s[W-1]) && (sum_s[W-1] != a_s[W-1]));
`ifdef ALUV_SAT_EN
            assign arith_s[g][l*W +: W] = (bus.sat && ov_s)
                ? (a_s[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}})
                : raw_s;
`else
            assign arith_s[g][l*W +: W] = raw_s;
`endif
            assign slt_s[g][l*W +: W] = {{(W-1){1'b0}}, ($signed(a_s) < $signed(b_s))};
            assign lane_ovf_s[g][l*(W/8) +: W/8] = {(W/8){ov_s}};
        end
    end

    // Result selection by command and lane width; reserved widths force zero with err.
    always_comb begin
        res_s = '0;
        ovf_s = '0;
        err_s = 1'b0;
        if (bus.dtype[2]) begin
            err_s = 1'b1;
        end else begin
            case (bus.command)
                3'd0, 3'd1: begin
                    res_s = arith_s[bus.dtype[1:0]];
                    ovf_s = lane_ovf_s[bus.dtype[1:0]];
                end
                3'd2:    res_s = bus.operandA ^ bus.operandB;
                3'd3:    res_s = slt_s[bus.dtype[1:0]];
                3'd4:    res_s = bus.operandA & bus.operandB;
                3'd5:    res_s = ~(bus.operandA & bus.operandB);
                3'd6:    res_s = ~(bus.operandA | bus.operandB);
                3'd7:    res_s = bus.operandA | bus.operandB;
                default: res_s = '0;
            endcase
        end
        zero_s = (res_s == '0);
    end

    // A stage may move when out_ready is high or any stage at or after it is empty.
    always_comb begin
        logic room_s;
        room_s = bus.out_ready;
        adv_s  = '0;
        for (int i = LAT - 1; i >= 0; i--) begin
            room_s   = room_s || !vld_r[i];
            adv_s[i] = room_s;
        end
    end

    // Pipeline registers: stage 0 captures the computed result, later stages shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_r  <= '0;
            err_r  <= '0;
            zero_r <= '0;
            for (int i = 0; i < LAT; i++) begin
                res_r[i] <= '0;
                ovf_r[i] <= '0;
            end
        end else begin
            if (adv_s[0]) begin
                vld_r[0]  <= bus.in_valid;
                res_r[0]  <= res_s;
                ovf_r[0]  <= ovf_s;
                err_r[0]  <= err_s;
                zero_r[0] <= zero_s;
            end
            for (int i = 1; i < LAT; i++) begin
                if (adv_s[i]) begin
                    vld_r[i]  <= vld_r[i-1];
                    res_r[i]  <= res_r[i-1];
                    ovf_r[i]  <= ovf_r[i-1];
                    err_r[i]  <= err_r[i-1];
                    zero_r[i] <= zero_r[i-1];
                end
            end
        end
    end

    assign bus.in_ready  = adv_s[0];
    assign bus.out_valid = vld_r[LAT-1];
    assign bus.result    = res_r[LAT-1];
    assign bus.ovf       = ovf_r[LAT-1];
    assign bus.err       = err_r[LAT-1];
    assign bus.iszero    = zero_r[LAT-1];
endmodule
